// File: rtl/cke_period_monitor.sv
// Clock-enable strobe monitor: period measurement, min/max, lock and loss.
// Optional macro CKE_MON_JITTER_EN adds a registered oJitter = oMax - oMin.
module cke_period_monitor #(
    parameter int pCntWidth = 16,
    parameter int pTimeout  = 1000,
    parameter int pLockCnt  = 4,
    parameter int pTol      = 1
) (
    input  logic                 iSysClk,
    input  logic                 iSysRst,
    input  logic                 iCke,
    input  logic                 iClr,
    output logic [pCntWidth-1:0] oPeriod,
    output logic                 oPeriodVld,
    output logic [pCntWidth-1:0] oMin,
    output logic [pCntWidth-1:0] oMax,
    output logic                 oLock,
    output logic                 oTimeout,
    output logic [pCntWidth-1:0] oJitter
);

    typedef enum logic [1:0] {
        IDLE,
        MEAS,
        LOCK,
        LOST
    } state_t;

    state_t               r_state;
    logic [pCntWidth-1:0] r_cnt;
    logic [pCntWidth-1:0] r_prev;
    logic                 r_prev_vld;
    logic [3:0]           r_match;
    logic [pCntWidth-1:0] r_period;
    logic                 r_vld;
    logic [pCntWidth-1:0] r_min;
    logic [pCntWidth-1:0] r_max;

    logic [pCntWidth-1:0] w_period;
    logic [pCntWidth-1:0] w_diff;
    logic                 w_match;
    logic [3:0]           w_match_inc;
    logic                 w_tmo;
    logic                 w_cnt_sat;

    // Period candidate, tolerance check against the previous period, timeout
    always_comb begin
        w_period    = r_cnt + pCntWidth'(1);
        w_diff      = (w_period >= r_prev) ? (w_period - r_prev)
                                           : (r_prev - w_period);
        w_match     = r_prev_vld && (w_diff <= pCntWidth'(pTol));
        w_match_inc = r_match + 4'd1;
        // Counter about to reach pTimeout-1: a pulse on the following edge
        // would measure pTimeout, so loss is declared on this edge instead.
        w_tmo       = (w_period == pCntWidth'(pTimeout - 1));
        w_cnt_sat   = &r_cnt;
    end

    // Monitor FSM with counter, statistics and registered outputs
    always_ff @(posedge iSysClk or posedge iSysRst) begin
        if (iSysRst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_prev     <= '0;
            r_prev_vld <= 1'b0;
            r_match    <= '0;
            r_period   <= '0;
            r_vld      <= 1'b0;
            r_min      <= '1;
            r_max      <= '0;
        end else begin
            r_vld <= 1'b0;
            if (iClr) begin
                r_state    <= IDLE;
                r_cnt      <= '0;
                r_prev_vld <= 1'b0;
                r_match    <= '0;
                r_min      <= '1;
                r_max      <= '0;
            end else begin
                if (r_state == IDLE || iCke) begin
                    r_cnt <= '0;
                end else if (!w_cnt_sat) begin
                    r_cnt <= r_cnt + pCntWidth'(1);
                end
                unique case (r_state)
                    IDLE, LOST: begin
                        if (iCke) begin
                            r_state <= MEAS;
                        end
                    end
                    MEAS, LOCK: begin
                        if (iCke) begin
                            r_period   <= w_period;
                            r_vld      <= 1'b1;
                            r_prev     <= w_period;
                            r_prev_vld <= 1'b1;
                            if (w_period < r_min) begin
                                r_min <= w_period;
                            end
                            if (w_period > r_max) begin
                                r_max <= w_period;
                            end
                            if (!w_match) begin
                                r_match <= '0;
                                r_state <= MEAS;
                            end else if (r_state == MEAS) begin
                                r_match <= w_match_inc;
                                if (w_match_inc == 4'(pLockCnt)) begin
                                    r_state <= LOCK;
                                end
                            end
                        end else if (w_tmo) begin
                            r_state    <= LOST;
                            r_match    <= '0;
                            r_prev_vld <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

    assign oPeriod    = r_period;
    assign oPeriodVld = r_vld;
    assign oMin       = r_min;
    assign oMax       = r_max;
    assign oLock      = (r_state == LOCK);
    assign oTimeout   = (r_state == LOST);

`ifdef CKE_MON_JITTER_EN
    logic [pCntWidth-1:0] r_jitter;

    // Spread of measured periods, zero until a first period exists
    always_ff @(posedge iSysClk or posedge iSysRst) begin
        if (iSysRst) begin
            r_jitter <= '0;
        end else begin
            r_jitter <= (r_min > r_max) ? '0 : (r_max - r_min);
        end
    end

    assign oJitter = r_jitter;
`else
    assign oJitter = '0;
`endif

endmodule

// File: tb/tb_cke_period_monitor.sv
// Directed bench for cke_period_monitor with default parameters.
// Honors CKE_MON_JITTER_EN for the expected oJitter value.
module tb_cke_period_monitor;

    logic        clk;
    logic        rst;
    logic        cke;
    logic        clr;
    logic [15:0] period;
    logic        vld;
    logic [15:0] pmin;
    logic [15:0] pmax;
    logic        lock;
    logic        tmo;
    logic [15:0] jit;

    int n_vec;
    int n_err;
    int vld_cnt;

    cke_period_monitor #(
        .pCntWidth(16),
        .pTimeout (1000),
        .pLockCnt (4),
        .pTol     (1)
    ) dut (
        .iSysClk   (clk),
        .iSysRst   (rst),
        .iCke      (cke),
        .iClr      (clr),
        .oPeriod   (period),
        .oPeriodVld(vld),
        .oMin      (pmin),
        .oMax      (pmax),
        .oLock     (lock),
        .oTimeout  (tmo),
        .oJitter   (jit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (vld === 1'b1) vld_cnt++;
    endtask

    task automatic pulse();
        cke = 1'b1;
        tick();
        cke = 1'b0;
    endtask

    task automatic wait_pulse(input int per);
        repeat (per - 1) tick();
        pulse();
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        vld_cnt = 0;
        rst     = 1'b0;
        cke     = 1'b0;
        clr     = 1'b0;

        // 1: asynchronous reset, no clock edge yet
        #3 rst = 1'b1;
        #1;
        chk("rst_period", period, 0);
        chk("rst_vld", vld, 0);
        chk("rst_min", pmin, 16'hFFFF);
        chk("rst_max", pmax, 0);
        chk("rst_lock", lock, 0);
        chk("rst_tmo", tmo, 0);
        chk("rst_jit", jit, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // 2: period 10, six pulses, lock after the sixth
        vld_cnt = 0;
        pulse();
        chk("t2_ref_novld", vld, 0);
        repeat (4) wait_pulse(10);
        chk("t2_nolock_5th", lock, 0);
        wait_pulse(10);
        chk("t2_vld_cnt", vld_cnt, 5);
        chk("t2_period", period, 10);
        chk("t2_min", pmin, 10);
        chk("t2_max", pmax, 10);
        chk("t2_lock", lock, 1);
        tick();
        chk("t2_jit", jit, 0);

        // 3: periods 10,11,10,13 from lock
        wait_pulse(10);
        chk("t3_lock_10", lock, 1);
        wait_pulse(11);
        chk("t3_period_11", period, 11);
        chk("t3_lock_11", lock, 1);
        wait_pulse(10);
        chk("t3_lock_10b", lock, 1);
        wait_pulse(13);
        chk("t3_vld_13", vld, 1);
        chk("t3_period_13", period, 13);
        chk("t3_unlock", lock, 0);
        chk("t3_max", pmax, 13);
        chk("t3_min", pmin, 10);
        tick();
`ifdef CKE_MON_JITTER_EN
        chk("t3_jit", jit, 3);
`else
        chk("t3_jit", jit, 0);
`endif

        // 4: strobe stops, loss after 999 cycles
        repeat (997) tick();
        chk("t4_tmo_early", tmo, 0);
        tick();
        chk("t4_tmo", tmo, 1);
        chk("t4_tmo_lock", lock, 0);
        pulse();
        chk("t4_ref_novld", vld, 0);
        chk("t4_tmo_clr", tmo, 0);
        wait_pulse(10);
        chk("t4_vld", vld, 1);
        chk("t4_period", period, 10);

        // 5: strobe every cycle, then clear coincident with a pulse
        cke = 1'b1;
        repeat (6) tick();
        chk("t5_period", period, 1);
        chk("t5_min", pmin, 1);
        chk("t5_lock", lock, 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("t5_clr_novld", vld, 0);
        chk("t5_clr_min", pmin, 16'hFFFF);
        chk("t5_clr_max", pmax, 0);
        chk("t5_clr_lock", lock, 0);
        chk("t5_clr_period", period, 1);
        vld_cnt = 0;
        tick();
        tick();
        cke = 1'b0;
        chk("t5_vld_cnt", vld_cnt, 1);
        chk("t5_min_after", pmin, 1);

        // 6: reset mid-period while locked
        repeat (5) wait_pulse(10);
        chk("t6_lock", lock, 1);
        repeat (4) tick();
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_lock", lock, 0);
        chk("t6_rst_min", pmin, 16'hFFFF);
        chk("t6_rst_period", period, 0);
        tick();
        tick();
        rst = 1'b0;
        pulse();
        chk("t6_ref_novld", vld, 0);
        wait_pulse(7);
        chk("t6_vld", vld, 1);
        chk("t6_period", period, 7);
        tick();
        chk("t6_jit", jit, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
